vga_timing_ctrl: RTL

//  Sequences the VGA pixel pipeline from the system clock.
//  - Embeds a divide-by-CLK_DIV clock-enable generator (pix_ce); no derived clocks.
//  - Runs horizontal/vertical counters and decodes hsync, vsync, display enable and pixel coordinates.
//  - Sits between the board clock and the pixel/colour generator; default 640x480@60 from 100 MHz.

---
 rtl/vga_timing_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   Generates VGA raster timing from the system clock. A divide-by-CLK_DIV
//   clock enable (pix_ce) paces horizontal/vertical counters; the counters
//   are decoded into registered sync, display-enable, coordinate and
//   line/frame pulse outputs. No derived clocks are created.
//
// Optional feature macro: VGA_FRAME_CNT_EN
//   When defined, adds a 16-bit free-running frame counter output.
//
// Ports
//   clk         in   system clock, all logic on rising edge
//   rst_n       in   synchronous active-low reset
//   en          in   run enable; low freezes the timing state
//   pix_ce      out  one-clk pixel strobe every CLK_DIV clks while en
//   hsync       out  horizontal sync, active level HSYNC_POL
//   vsync       out  vertical sync, active level VSYNC_POL
//   de          out  display enable (visible region and en)
//   x, y        out  pixel column/row while de, else 0
//   line_start  out  one-clk pulse when outputs first reflect h wrap to 0
//   frame_start out  one-clk pulse when outputs first reflect (h,v) wrap to (0,0)
//   frame_cnt   out  (VGA_FRAME_CNT_EN only) count of frame_start pulses
module vga_timing_ctrl #(
  parameter int   CLK_DIV   = 4,
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_ce,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic             h_wrap_q, h_wrap_d;
  logic             v_wrap_q, v_wrap_d;
  logic             pix_ce_q, pix_ce_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             advance;

  // Divider: the strobe is registered, so the counters step one clk after
  // the divider reaches its last count. en gates the step as well so that a
  // strobe already in flight when en drops cannot move the counters.
  always_comb begin
    div_cnt_d = div_cnt_q;
    pix_ce_d  = 1'b0;
    if (en) begin
      pix_ce_d  = (div_cnt_q == DIV_LAST);
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end
  end

  assign advance = pix_ce_q && en;

  // Raster counters. The wrap flags mark the edge where the counters wrapped
  // so the pulses can be issued together with the first decode of (0,v)/(0,0).
  always_comb begin
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    h_wrap_d = 1'b0;
    v_wrap_d = 1'b0;
    if (advance) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d  = '0;
        h_wrap_d = 1'b1;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d  = '0;
          v_wrap_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Output decode from the current counters; frozen counters keep syncs steady.
  always_comb begin
    hsync_d       = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    de_d          = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT) && en;
    x_d           = de_d ? h_cnt_q : '0;
    y_d           = de_d ? v_cnt_q : '0;
    line_start_d  = h_wrap_q;
    frame_start_d = v_wrap_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_wrap_q      <= 1'b0;
      v_wrap_q      <= 1'b0;
      pix_ce_q      <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_wrap_q      <= h_wrap_d;
      v_wrap_q      <= v_wrap_d;
      pix_ce_q      <= pix_ce_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Steps together with frame_start so the new count is visible with the pulse.
  always_comb begin
    frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign pix_ce      = pix_ce_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
